// File: rtl/matvec_pkg.sv
// Shared types and constants for the 8x8 matrix-vector datapath and its requantizer.
package matvec_pkg;

    localparam int IN_W    = 28;
    localparam int OUT_W   = 14;
    localparam int K       = 8;

    localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUT_W - 1));

    typedef logic signed [IN_W-1:0]  acc_t;
    typedef logic signed [OUT_W-1:0] elem_t;

endpackage

// File: rtl/matvec_requant_fifo_if.sv
// Stream bus between the dot-product source, the requantizer and the downstream consumer.
interface matvec_requant_fifo_if #(
    parameter int DEPTH   = 8,
    parameter int SHIFT_W = 5
);
    import matvec_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    acc_t                         in_data;
    logic [SHIFT_W-1:0]           shift;
    logic                         out_valid;
    logic                         out_ready;
    elem_t                        out_data;
    logic                         out_last;
    logic [$clog2(DEPTH+1)-1:0]   level;

    modport slave (
        input  in_valid, in_data, shift, out_ready,
        output in_ready, out_valid, out_data, out_last, level
    );

    modport master (
        output in_valid, in_data, shift, out_ready,
        input  in_ready, out_valid, out_data, out_last, level
    );

endinterface

// File: rtl/matvec_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; reads of an empty FIFO return zero.
module matvec_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_wr_en,
    input  logic [W-1:0]                i_wr_data,
    input  logic                        i_rd_en,
    output logic [W-1:0]                o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0]  o_level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_pop  = i_rd_en && (r_level != '0);
    assign w_push = i_wr_en && ((r_level != LVL_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_level   = r_level;

endmodule

// File: rtl/matvec_requant_fifo.sv
// Requantizes 28-bit dot products to 14-bit (round-half-up shift, saturate) and buffers them
// with a per-vector last marker. Define MATVEC_REQUANT_RELU_EN to clamp negatives to zero.
module matvec_requant_fifo #(
    parameter int IN_W    = matvec_pkg::IN_W,
    parameter int OUT_W   = matvec_pkg::OUT_W,
    parameter int DEPTH   = 8,
    parameter int K       = matvec_pkg::K,
    parameter int SHIFT_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    matvec_requant_fifo_if.slave    bus
);
    import matvec_pkg::*;

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    function automatic logic signed [IN_W:0] round_shift(
        input logic signed [IN_W-1:0] x,
        input logic [SHIFT_W-1:0]     sh
    );
        logic [SHIFT_W-1:0]     s;
        logic signed [IN_W:0]   ext;
        logic signed [IN_W:0]   rnd;
        s   = (sh > SHIFT_W'(IN_W - 1)) ? SHIFT_W'(IN_W - 1) : sh;
        ext = {x[IN_W-1], x};
        rnd = '0;
        if (s != '0) rnd = (IN_W+1)'(1) << (s - SHIFT_W'(1));
        // One guard bit keeps the rounding carry from wrapping at the positive extreme.
        return (ext + rnd) >>> s;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W:0] t);
        if (t > (IN_W+1)'(SAT_MAX))      return OUT_W'(SAT_MAX);
        else if (t < (IN_W+1)'(SAT_MIN)) return OUT_W'(SAT_MIN);
        else                             return t[OUT_W-1:0];
    endfunction

`ifdef MATVEC_REQUANT_RELU_EN
    function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] v);
        return v[OUT_W-1] ? '0 : v;
    endfunction
`endif

    logic                        r_vld_p1;
    logic signed [OUT_W-1:0]     r_data_p1;
    logic [CNT_W-1:0]            r_cnt;
    logic signed [OUT_W-1:0]     w_req;
    logic                        w_in_ready;
    logic                        w_accept;
    logic [LVL_W-1:0]            w_level;
    logic [OUT_W-1:0]            w_head;
    logic                        w_out_valid;
    logic                        w_out_hs;

`ifdef MATVEC_REQUANT_RELU_EN
    assign w_req = relu(saturate(round_shift(bus.in_data, bus.shift)));
`else
    assign w_req = saturate(round_shift(bus.in_data, bus.shift));
`endif

    // The pipeline slot counts against capacity, so a write into the FIFO can never be refused.
    assign w_in_ready = reset &&
        (((LVL_W+1)'(w_level) + (LVL_W+1)'(r_vld_p1)) < (LVL_W+1)'(DEPTH));
    assign w_accept   = bus.in_valid && w_in_ready;

    // ---- stage p1: requantized result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_vld_p1 <= 1'b0;
        else        r_vld_p1 <= w_accept;
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_data_p1 <= w_req;
    end

    // ---- stage p2: FIFO write and show-ahead output
    matvec_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (OUT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .i_wr_en   (r_vld_p1),
        .i_wr_data (r_data_p1),
        .i_rd_en   (bus.out_ready),
        .o_rd_data (w_head),
        .o_level   (w_level)
    );

    assign w_out_valid = (w_level != '0);
    assign w_out_hs    = w_out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_cnt == CNT_W'(K - 1)) r_cnt <= '0;
            else                        r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_head;
    assign bus.out_last  = w_out_valid && (r_cnt == CNT_W'(K - 1));
    assign bus.level     = w_level;

endmodule

// File: tb/tb_matvec_requant_fifo.sv
// Directed bench for matvec_requant_fifo: requantization, saturation, backpressure, last marker, reset.
module tb_matvec_requant_fifo;
    import matvec_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    bit   done;

    elem_t got_q[$];
    logic  last_q[$];
    int    exp_q[$];

    matvec_requant_fifo_if #(.DEPTH(8), .SHIFT_W(5)) bus ();

    matvec_requant_fifo #(
        .IN_W(28), .OUT_W(14), .DEPTH(8), .K(8), .SHIFT_W(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            last_q.push_back(bus.out_last);
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one result and returns just after the edge that accepted it (in_valid left high).
    task automatic send(input acc_t d, input logic [4:0] sh);
        logic acc;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.shift    = sh;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(posedge clk);
            acc = bus.in_ready;
            #1;
            n++;
        end
        check("send_accepted", acc, 1);
    endtask

    task automatic verify(input string tag, input int base);
        check({tag, "_count"}, got_q.size(), base + exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) begin
                check($sformatf("%s_data[%0d]", tag, i), got_q[base + i], exp_q[i]);
                check($sformatf("%s_last[%0d]", tag, i), last_q[base + i], ((base + i) % 8 == 7) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int base;
        tests = 0;
        fails = 0;
        done  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.shift     = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) step();
        check("rst_in_ready",  bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_level",     bus.level, 0);
        check("rst_out_data",  bus.out_data, 0);
        check("rst_out_last",  bus.out_last, 0);
        reset = 1'b1;
        step();
        check("post_rst_in_ready", bus.in_ready, 1);

        // Basic requantization with shift 4 and latency check
        bus.out_ready = 1'b1;
        base = got_q.size();
        send(28'sd1000, 5'd4);
        check("lat_edge1_out_valid", bus.out_valid, 0);
        send(-28'sd1000, 5'd4);
        check("lat_edge2_out_valid", bus.out_valid, 1);
        check("lat_edge2_out_data",  bus.out_data, 63);
        send(28'sd8, 5'd4);
        send(28'sd7, 5'd4);
        bus.in_valid = 1'b0;
        repeat (6) step();
        exp_q = '{63, -62, 1, 0};
        verify("basic", base);

        // Saturation, shift clamp and rounding boundaries
        base = got_q.size();
        send(28'sd8191, 5'd0);
        send(28'sd8192, 5'd0);
        send(-28'sd8193, 5'd0);
        send(28'sh7FFFFFF, 5'd0);
        send(28'sh7FFFFFF, 5'd27);
        send(28'sh7FFFFFF, 5'd31);
        send(28'sh8000000, 5'd27);
        send(-28'sd3, 5'd1);
        send(28'sd3, 5'd1);
        bus.in_valid = 1'b0;
        repeat (6) step();
        exp_q = '{8191, 8191, -8192, 8191, 1, 1, -1, -1, 2};
        verify("sat", base);

        // Backpressure: eight results fill the pipeline plus FIFO
        bus.out_ready = 1'b0;
        base = got_q.size();
        for (int i = 0; i < 8; i++) send(28'(100 + i), 5'd0);
        bus.in_data = 28'sd108;
        check("bp_in_ready_low", bus.in_ready, 0);
        step();
        check("bp_level_full", bus.level, 8);
        step();
        check("bp_level_hold",     bus.level, 8);
        check("bp_in_ready_hold",  bus.in_ready, 0);
        check("bp_head_hold",      bus.out_data, 100);
        bus.out_ready = 1'b1;
        step();
        check("bp_level_after_pop",    bus.level, 7);
        check("bp_in_ready_after_pop", bus.in_ready, 1);
        send(28'sd108, 5'd0);
        send(28'sd109, 5'd0);
        bus.in_valid = 1'b0;
        repeat (14) step();
        exp_q = '{100, 101, 102, 103, 104, 105, 106, 107, 108, 109};
        verify("bp", base);

        // Asynchronous reset in the middle of a stalled burst
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(28'(300 + i), 5'd0);
        bus.in_valid = 1'b0;
        step();
        check("mid_level_before", bus.level, 5);
        #3 reset = 1'b0;
        #1;
        check("mid_out_valid", bus.out_valid, 0);
        check("mid_level",     bus.level, 0);
        check("mid_in_ready",  bus.in_ready, 0);
        check("mid_out_last",  bus.out_last, 0);
        #10 reset = 1'b1;
        got_q.delete();
        last_q.delete();
        step();

        // Sixteen results with random downstream gaps
        base = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(28'(16 * (500 + i)), 5'd4);
                bus.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        bus.out_ready = 1'b1;
        repeat (20) step();
        exp_q = '{500, 501, 502, 503, 504, 505, 506, 507,
                  508, 509, 510, 511, 512, 513, 514, 515};
        verify("last", base);

        // Sign handling (clamped to zero in the ReLU build)
        base = got_q.size();
        send(-28'sd5, 5'd0);
        send(28'sd5, 5'd0);
        bus.in_valid = 1'b0;
        repeat (6) step();
`ifdef MATVEC_REQUANT_RELU_EN
        exp_q = '{0, 5};
`else
        exp_q = '{-5, 5};
`endif
        verify("sign", base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matvec_requant_fifo.md
Name: matvec_requant_fifo

Overview:
- Downstream stage of the 8x8 matrix-vector multiplier.
- Consumes the 28-bit signed dot-product stream over valid/ready and requantizes each result to 14-bit signed, using a rounding arithmetic right shift and then saturation.
- Buffers results in a small FIFO and emits them with a per-vector last marker.
- The 14-bit output matches the multiplier's input_data format, so layers can be chained.

Parameters:
- IN_W, 28, input result width (signed).
- OUT_W, 14, output width (signed).
- DEPTH, 8, FIFO entries (power of two, >=2).
- K, 8, elements per output vector (drives out_last).
- SHIFT_W, 5, width of the shift control.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept a result.
- in_data  input  IN_W  signed dot-product result.
- shift  input  SHIFT_W  right-shift amount, sampled with each accepted result.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts the head.
- out_data  output  OUT_W  requantized signed result.
- out_last  output  1  head is element K-1 of its vector.
- level  output  $clog2(DEPTH+1)  FIFO occupancy, excluding the pipeline register.

Behaviour:
- Reset, asserted asynchronously:
  - FIFO pointers and level = 0.
  - Pipeline valid = 0; out_valid = 0; out_data = 0; out_last = 0.
  - Element counter = 0; in_ready = 0 while reset is asserted.
- Accept: an input handshake occurs when in_valid && in_ready at a rising edge.
- in_ready is registered-path only, with no combinational path from out_ready:
  - in_ready = (level + pipe_valid) < DEPTH, using the values at the start of the cycle.
  - A pop in the same cycle does not raise in_ready until the next cycle.
- Stage 1 (pipeline register), on accept:
  - s = min(shift, IN_W-1).
  - Compute in IN_W+1 bits: t = (in_data + (s>0 ? 1<<(s-1) : 0)) >>> s. Rounding is half toward +inf.
  - Saturate t to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-8192, 8191].
  - Store the result; pipe_valid = 1.
  - pipe_valid clears on the next edge unless a new accept occurs.
- Stage 2: if pipe_valid, the pipeline content is written to FIFO[wr_ptr] on the next edge; wr_ptr++ and level++.
  - A write is never blocked, because in_ready already reserved the space.
- Latency: accept at edge N -> FIFO write at edge N+1 -> out_valid = 1 after edge N+1 if the FIFO was empty.
- Output (show-ahead):
  - out_data = FIFO[rd_ptr]; out_valid = (level != 0).
  - On out_valid && out_ready: rd_ptr++ and level--.
- Simultaneous write and pop: level unchanged, both pointers advance.
  - When level == DEPTH with a pending pop, no write can be pending (reservation rule).
- Pointers wrap modulo DEPTH.
- out_data, out_valid and out_last hold stable while out_valid && !out_ready.
- Element counter: increments on each output handshake and wraps K-1 -> 0. out_last = out_valid && (counter == K-1).
- Throughput: 1 result/cycle sustained when out_ready is held high.

Optional Feature:
- Macro: MATVEC_REQUANT_RELU_EN.
- Defined: after saturation, negative values are forced to 0 before the FIFO write (ReLU).
- Undefined: signed values pass through unchanged.
- Latency and handshakes are identical in both builds.

Decomposition:
- Shared package matvec_pkg:
  - constants IN_W=28, OUT_W=14, K=8;
  - typedefs acc_t (logic signed [27:0]) and elem_t (logic signed [13:0]);
  - SAT_MAX/SAT_MIN localparams.
- Sub-module matvec_sync_fifo (DEPTH x OUT_W, show-ahead, level output), reusable elsewhere.
- Requantization logic stays inline in this block.

Test Plan:
- Basic requantization, shift=4, out_ready=1, inputs 1000, -1000, 8, 7 -> outputs 63, -62, 1, 0; first out_valid two edges after the first accept.
- Saturation, shift=0, inputs 8191, 8192, -8193, 0x7FFFFFF -> 8191, 8191, -8192, 8191. Rounding carry with shift=27, in=0x7FFFFFF -> 1 (no wrap).
- Backpressure, out_ready=0, push 10 values:
  - in_ready falls after 8 accepts; level=8.
  - Then out_ready=1: the 8 values drain in order, in_ready returns one cycle after the first pop, and the remaining 2 follow.
- out_last, stream 16 results with random out_ready gaps: out_last high exactly on the 8th and 16th handshakes.
- Reset mid-operation, level=5, assert reset asynchronously between edges: out_valid and level drop to 0 immediately. After release, the first new input is the first output and the counter restarts (out_last on the 8th).
- MATVEC_REQUANT_RELU_EN build, shift=0, inputs -5, 5 -> 0, 5. Without the macro -> -5, 5.
